// File: rtl/morse_cal_sequencer_pkg.sv
// Shared encodings for the Morse calibration sequencer and the calibration block.
// Mode and sequencer state codes, plus the calibration "result valid" state code.
package morse_cal_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_CAL  = 2'd1,
        MODE_RUN  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        ST_CLR   = 2'd0,
        ST_CAL   = 2'd1,
        ST_LATCH = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_e;

    localparam logic [2:0] CALC_CODE = 3'b101;

    function automatic mode_e state_to_mode(input seq_state_e s);
        case (s)
            ST_CAL, ST_LATCH: return MODE_CAL;
            ST_RUN:           return MODE_RUN;
            default:          return MODE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/morse_duration_counter.sv
// Saturating duration counter. A clear restarts the count at 1 when the
// enable is also active, so a run of N enabled cycles reads back as N.
module morse_duration_counter #(
    parameter int unsigned CNT_W = 31
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= en ? CNT_ONE : '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/morse_cal_sequencer.sv
// Sequencer between the debounced button and the calibration/decoder blocks:
// drives calibration strobes, latches the unit time, then classifies symbols and gaps.
module morse_cal_sequencer #(
    parameter int unsigned CNT_W       = 31,
    parameter int unsigned LONG_THRESH = 25000000,
    parameter int unsigned IDLE_LIMIT  = 500000000,
    parameter logic [2:0]  CALC_CODE   = morse_cal_sequencer_pkg::CALC_CODE
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Btn,
    input  logic             Recal,
    input  logic [2:0]       Cal_State,
    input  logic [CNT_W-1:0] Cal_Timeout,
    output logic             Cal_Start,
    output logic             Cal_Reset,
    output logic             Cal_S,
    output logic             Cal_L,
    output logic             Sym_Valid,
    output logic             Sym_Dash,
    output logic             Letter_End,
    output logic             Word_End,
    output logic [1:0]       Mode,
    output logic [CNT_W-1:0] Unit
);

    import morse_cal_sequencer_pkg::*;

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_THRESH);
    localparam logic [CNT_W-1:0] IDLE_T = CNT_W'(IDLE_LIMIT);

    seq_state_e state, state_d;

    logic             btn_q;
    logic             armed;
    logic             press_ok;
    logic             sym_seen;
    logic             letter_done;
    logic             rise, fall, gap_active, clr_all, abort;
    logic [CNT_W-1:0] press_cnt, gap_cnt;
    logic [CNT_W-1:0] unit_q, unit_d;
    logic [CNT_W+1:0] unit_x3;

    logic cal_s_p0, cal_l_p0, vld_p0, dash_p0, letter_p0, word_p0;
    logic cal_s_p1, cal_l_p1, vld_p1, dash_p1, letter_p1, word_p1;

    assign rise       = Btn & ~btn_q;
    assign fall       = ~Btn & btn_q;
    assign gap_active = ~Btn & ~btn_q;
    assign clr_all    = (state == ST_CLR);
    assign abort      = ~Btn && (gap_cnt >= IDLE_T);
    assign unit_x3    = {2'b00, unit_q} + {1'b0, unit_q, 1'b0};

    morse_duration_counter #(.CNT_W(CNT_W)) u_press_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (rise | clr_all),
        .en    (Btn),
        .count (press_cnt)
    );

    morse_duration_counter #(.CNT_W(CNT_W)) u_gap_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (fall | clr_all),
        .en    (~Btn),
        .count (gap_cnt)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ST_CLR;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        unit_d    = unit_q;
        cal_s_p0  = 1'b0;
        cal_l_p0  = 1'b0;
        vld_p0    = 1'b0;
        dash_p0   = 1'b0;
        letter_p0 = 1'b0;
        word_p0   = 1'b0;
        case (state)
            ST_CLR: begin
                state_d = ST_CAL;
            end
            ST_CAL: begin
                if (abort) begin
                    state_d = ST_CLR;
                end else begin
                    if (fall && press_ok) begin
                        cal_l_p0 = (press_cnt >= LONG_T);
                        cal_s_p0 = (press_cnt <  LONG_T);
                    end
                    if (Cal_State == CALC_CODE) begin
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                unit_d  = Cal_Timeout;
                state_d = (Cal_Timeout == '0) ? ST_CLR : ST_RUN;
            end
            ST_RUN: begin
                if (Recal) begin
                    state_d = ST_CLR;
                end else begin
                    if (fall && press_ok) begin
                        vld_p0  = 1'b1;
                        dash_p0 = (press_cnt >= unit_q);
                    end
                    if (gap_active && sym_seen) begin
                        letter_p0 = !letter_done && (gap_cnt == unit_q);
                        word_p0   = ({2'b00, gap_cnt} == unit_x3);
                    end
                end
            end
            default: begin
                state_d = ST_CLR;
            end
        endcase
    end

    // Stage p1: registered strobes and press/gap bookkeeping
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            unit_q      <= '0;
            btn_q       <= 1'b0;
            armed       <= 1'b0;
            press_ok    <= 1'b0;
            sym_seen    <= 1'b0;
            letter_done <= 1'b0;
            cal_s_p1    <= 1'b0;
            cal_l_p1    <= 1'b0;
            vld_p1      <= 1'b0;
            dash_p1     <= 1'b0;
            letter_p1   <= 1'b0;
            word_p1     <= 1'b0;
        end else begin
            unit_q <= unit_d;
            btn_q  <= Btn;
            // A press only counts if the button was seen released after reset
            armed  <= armed | ~Btn;

            if (clr_all || fall) begin
                press_ok <= 1'b0;
            end else if (rise) begin
                press_ok <= armed;
            end

            if (clr_all || word_p0) begin
                sym_seen <= 1'b0;
            end else if (vld_p0) begin
                sym_seen <= 1'b1;
            end

            if (clr_all || fall) begin
                letter_done <= 1'b0;
            end else if (letter_p0) begin
                letter_done <= 1'b1;
            end

            cal_s_p1  <= cal_s_p0;
            cal_l_p1  <= cal_l_p0;
            vld_p1    <= vld_p0;
            dash_p1   <= dash_p0;
            letter_p1 <= letter_p0;
            word_p1   <= word_p0;
        end
    end

    assign Cal_Reset  = (state == ST_CLR);
    assign Cal_Start  = (state == ST_CAL) || (state == ST_LATCH);
    assign Cal_S      = cal_s_p1;
    assign Cal_L      = cal_l_p1;
    assign Sym_Valid  = vld_p1;
    assign Sym_Dash   = dash_p1;
    assign Letter_End = letter_p1;
    assign Word_End   = word_p1;
    assign Mode       = state_to_mode(state);
    assign Unit       = unit_q;

endmodule

// File: tb/tb_morse_cal_sequencer.sv
// Bench for morse_cal_sequencer: table-driven calibration presses, hand-written RUN
// and abort sequences, with every strobe matched against a queue of expected events.
module tb_morse_cal_sequencer;

    localparam int unsigned CNT_W  = 31;
    localparam int unsigned LONG_T = 250;
    localparam int unsigned IDLE_T = 1000;
    localparam int unsigned U      = 5000;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Btn;
    logic             Recal;
    logic [2:0]       Cal_State;
    logic [CNT_W-1:0] Cal_Timeout;
    logic             Cal_Start, Cal_Reset, Cal_S, Cal_L;
    logic             Sym_Valid, Sym_Dash, Letter_End, Word_End;
    logic [1:0]       Mode;
    logic [CNT_W-1:0] Unit;

    morse_cal_sequencer #(
        .CNT_W       (CNT_W),
        .LONG_THRESH (LONG_T),
        .IDLE_LIMIT  (IDLE_T),
        .CALC_CODE   (3'b101)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Btn         (Btn),
        .Recal       (Recal),
        .Cal_State   (Cal_State),
        .Cal_Timeout (Cal_Timeout),
        .Cal_Start   (Cal_Start),
        .Cal_Reset   (Cal_Reset),
        .Cal_S       (Cal_S),
        .Cal_L       (Cal_L),
        .Sym_Valid   (Sym_Valid),
        .Sym_Dash    (Sym_Dash),
        .Letter_End  (Letter_End),
        .Word_End    (Word_End),
        .Mode        (Mode),
        .Unit        (Unit)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef enum int {EV_CALRST, EV_CALS, EV_CALL, EV_DOT, EV_DASH, EV_LETTER, EV_WORD} ev_e;
    typedef struct {
        ev_e         kind;
        int unsigned at;
    } exp_t;
    typedef struct {
        int press;
        int gap;
        bit is_long;
    } cal_vec_t;

    exp_t     sb[$];
    cal_vec_t cv[10];
    int       total = 0;
    int       bad   = 0;

    function automatic void expect_ev(input ev_e k, input int unsigned at);
        exp_t e;
        e.kind = k;
        e.at   = at;
        sb.push_back(e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic flush_missed();
        exp_t e;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missed_strobe: got nothing expected %s at cycle %0d", e.kind.name(), e.at);
        end
    endtask

    task automatic seen(input ev_e k);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got %s at cycle %0d expected none", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.at != cyc) begin
                bad++;
                $display("FAIL strobe: got %s at cycle %0d expected %s at cycle %0d",
                         k.name(), cyc, e.kind.name(), e.at);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press(input int n, output int unsigned rel);
        tick(1);
        Btn = 1'b1;
        tick(n);
        Btn = 1'b0;
        rel = cyc;
    endtask

    initial begin
        int unsigned rel;
        int unsigned clr_at;

        Reset       = 1'b1;
        Btn         = 1'b0;
        Recal       = 1'b0;
        Cal_State   = 3'b000;
        Cal_Timeout = '0;

        fork
            forever begin
                @(negedge Clk);
                if (!Reset) begin
                    flush_missed();
                    if (Cal_Reset)  seen(EV_CALRST);
                    if (Cal_S)      seen(EV_CALS);
                    if (Cal_L)      seen(EV_CALL);
                    if (Sym_Valid)  seen(Sym_Dash ? EV_DASH : EV_DOT);
                    if (Letter_End) seen(EV_LETTER);
                    if (Word_End)   seen(EV_WORD);
                end
            end
        join_none

        cv = '{'{100, 50, 1'b0}, '{100, 50, 1'b0}, '{100, 50, 1'b0}, '{100, 50, 1'b0},
               '{400, 50, 1'b1}, '{400, 50, 1'b1}, '{400, 50, 1'b1}, '{400, 50, 1'b1},
               '{249, 50, 1'b0}, '{250, 50, 1'b1}};

        // Reset values
        tick(3);
        @(negedge Clk);
        check("rst_mode",    64'(Mode), 64'd0);
        check("rst_start",   64'(Cal_Start), 64'd0);
        check("rst_unit",    64'(Unit), 64'd0);
        check("rst_strobes", 64'({Cal_S, Cal_L, Sym_Valid, Letter_End, Word_End}), 64'd0);

        tick(1);
        Reset = 1'b0;
        expect_ev(EV_CALRST, cyc);
        @(negedge Clk);
        check("clr_mode", 64'(Mode), 64'd0);
        tick(1);
        @(negedge Clk);
        check("cal_mode",  64'(Mode), 64'd1);
        check("cal_start", 64'(Cal_Start), 64'd1);

        // Calibration presses: short/long classification
        for (int i = 0; i < 10; i++) begin
            press(cv[i].press, rel);
            expect_ev(cv[i].is_long ? EV_CALL : EV_CALS, rel + 1);
            tick(cv[i].gap);
        end

        // Calibration result valid -> LATCH -> RUN
        tick(1);
        Cal_State   = 3'b101;
        Cal_Timeout = CNT_W'(U);
        @(negedge Clk);
        check("pre_latch_mode", 64'(Mode), 64'd1);
        tick(1);
        Cal_State = 3'b000;
        @(negedge Clk);
        check("latch_start", 64'(Cal_Start), 64'd1);
        check("latch_unit",  64'(Unit), 64'd0);
        tick(1);
        @(negedge Clk);
        check("run_mode",  64'(Mode), 64'd2);
        check("run_unit",  64'(Unit), 64'(U));
        check("run_start", 64'(Cal_Start), 64'd0);

        // RUN: dot/dash around the unit boundary, then letter and word gaps
        press(3000, rel); expect_ev(EV_DOT, rel + 1);  tick(1000);
        press(6000, rel); expect_ev(EV_DASH, rel + 1); tick(1000);
        press(4999, rel); expect_ev(EV_DOT, rel + 1);  tick(1000);
        press(5000, rel); expect_ev(EV_DASH, rel + 1);
        expect_ev(EV_LETTER, rel + 1 + U);
        expect_ev(EV_WORD,   rel + 1 + 3 * U);
        tick(20000);

        // Re-press before the letter threshold suppresses both gap strobes
        press(100, rel); expect_ev(EV_DOT, rel + 1);
        tick(4000);
        press(100, rel); expect_ev(EV_DOT, rel + 1);
        tick(1000);

        // Recal coincident with a fall: symbol dropped, back to CLR, Unit held
        tick(1);
        Btn = 1'b1;
        tick(100);
        Btn   = 1'b0;
        Recal = 1'b1;
        rel   = cyc;
        expect_ev(EV_CALRST, rel + 1);
        tick(1);
        Recal  = 1'b0;
        clr_at = cyc;
        @(negedge Clk);
        check("recal_mode", 64'(Mode), 64'd0);
        check("recal_unit", 64'(Unit), 64'(U));
        tick(1);
        @(negedge Clk);
        check("recal_cal_mode", 64'(Mode), 64'd1);

        // Idle abort in CAL
        expect_ev(EV_CALRST, clr_at + IDLE_T + 1);
        tick(IDLE_T + 5);
        check("abort_mode", 64'(Mode), 64'd1);

        // Zero calibration result returns to CLR
        Cal_State   = 3'b101;
        Cal_Timeout = '0;
        expect_ev(EV_CALRST, cyc + 2);
        tick(1);
        Cal_State = 3'b000;
        tick(1);
        @(negedge Clk);
        check("bad_cal_mode", 64'(Mode), 64'd0);
        check("bad_cal_unit", 64'(Unit), 64'd0);
        tick(1);
        @(negedge Clk);
        check("bad_cal_back", 64'(Mode), 64'd1);

        // Calibrate again, then reset in the middle of a RUN press
        tick(1);
        Cal_State   = 3'b101;
        Cal_Timeout = CNT_W'(200);
        tick(1);
        Cal_State = 3'b000;
        tick(1);
        @(negedge Clk);
        check("run2_mode", 64'(Mode), 64'd2);
        check("run2_unit", 64'(Unit), 64'd200);
        tick(1);
        Btn = 1'b1;
        tick(50);
        #2;
        Reset = 1'b1;
        @(negedge Clk);
        check("midrst_mode",    64'(Mode), 64'd0);
        check("midrst_unit",    64'(Unit), 64'd0);
        check("midrst_start",   64'(Cal_Start), 64'd0);
        check("midrst_strobes", 64'({Cal_S, Cal_L, Sym_Valid, Letter_End, Word_End}), 64'd0);
        tick(1);
        Reset = 1'b0;
        expect_ev(EV_CALRST, cyc);
        tick(50);
        Btn = 1'b0;
        tick(20);
        check("midrst_cal_mode", 64'(Mode), 64'd1);
        press(100, rel); expect_ev(EV_CALS, rel + 1);
        tick(20);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
